// File: rtl/add_mul_seq_ctrl.sv
// add_mul_seq_ctrl: iterative sequencer computing P = (XS + XC) * Y.
// Each BUSY cycle handles one multiplier digit d = XS[i] + XC[i] in {0,1,2}
// and adds d*Y*2^i to the accumulator. Valid/ready handshakes sit on both
// the operand side and the result side.
// Optional build macro: ADD_MUL_SEQ_EARLY_TERM_EN. When it is defined, the
// sequence stops as soon as no nonzero digit remains above the current one.
module add_mul_seq_ctrl #(
    parameter int widthX = 8,
    parameter int widthY = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [widthX-1:0]        XS_i,
    input  logic [widthX-1:0]        XC_i,
    input  logic [widthY-1:0]        Y_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [widthX+widthY:0]   P_o,
    input  logic                     flush_i,
    output logic                     busy_o
);

    localparam int widthP = widthX + widthY + 1;
    localparam int CW     = $clog2(widthX + 1);
    localparam logic [CW-1:0] LAST = CW'(widthX - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [widthP-1:0]   acc_q;
    logic [widthX-1:0]   xs_q, xc_q;
    logic [widthY-1:0]   y_q;

    logic [widthX-1:0]   m1, m2, digit_sel;
    logic                m1_bit, m2_bit;
    logic                last;
    logic                accept, step;

    // Contribution of one recoded digit: M1 adds Y<<i, M2 adds Y<<(i+1).
    // The total never exceeds (2^widthX-1)*2*(2^widthY-1), so widthP is exact.
    function automatic logic [widthP-1:0] digit_term(
        input logic              sel1,
        input logic              sel2,
        input logic [widthY-1:0] y,
        input logic [CW-1:0]     sh
    );
        logic [widthP-1:0] ye;
        logic [widthP-1:0] t;
        ye = widthP'(y) << sh;
        t  = '0;
        if (sel1) t = t + ye;
        if (sel2) t = t + (ye << 1);
        return t;
    endfunction

    assign m1        = xs_q ^ xc_q;
    assign m2        = xs_q & xc_q;
    assign digit_sel = widthX'(1) << cnt_q;
    assign m1_bit    = |(m1 & digit_sel);
    assign m2_bit    = |(m2 & digit_sel);

`ifdef ADD_MUL_SEQ_EARLY_TERM_EN
    // Digits still pending above the one handled this cycle.
    logic [widthX-1:0] remaining;
    assign remaining = ((xs_q | xc_q) >> cnt_q) >> 1;
    assign last      = (cnt_q == LAST) || (remaining == '0);
`else
    assign last      = (cnt_q == LAST);
`endif

    // flush_i outranks every other action, so it gates accept and step.
    assign accept = (state_q == IDLE) && in_valid_i && !flush_i;
    assign step   = (state_q == BUSY) && !flush_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid_i)  state_d = BUSY;
                BUSY:    if (last)        state_d = DONE;
                DONE:    if (out_ready_i) state_d = IDLE;
                default:                  state_d = IDLE;
            endcase
        end
    end

    // Operand latch, digit counter and accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
            xs_q  <= '0;
            xc_q  <= '0;
            y_q   <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            xs_q  <= XS_i;
            xc_q  <= XC_i;
            y_q   <= Y_i;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_q + digit_term(m1_bit, m2_bit, y_q, cnt_q);
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign P_o         = acc_q;

endmodule

// File: tb/tb_add_mul_seq_ctrl.sv
// Directed bench for add_mul_seq_ctrl at widthX = widthY = 8.
// Expected latency follows ADD_MUL_SEQ_EARLY_TERM_EN when it is defined.
module tb_add_mul_seq_ctrl;

`ifdef ADD_MUL_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  xs, xc, y;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] p;
    logic        flush;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;
    int seen;

    add_mul_seq_ctrl #(.widthX(8), .widthY(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .XS_i        (xs),
        .XC_i        (xc),
        .Y_i         (y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .P_o         (p),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycles from accept edge to out_valid.
    function automatic int lat(input int a, input int b);
        int v;
        int h;
        v = a | b;
        h = 0;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return ET ? h + 1 : 8;
    endfunction

    // Present operands for one accept edge, scramble the sources afterwards,
    // then count cycles until out_valid (bounded).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         output int cyc);
        xs = a; xc = b; y = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        xs = ~a; xc = ~b; y = ~c;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        xs = '0; xc = '0; y = '0;
        #23;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_p",         32'(p),         32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 3 + 5 = 8, * 7 = 56
        xs = 8'd3; xc = 8'd5; y = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; xs = 8'd200; xc = 8'd100; y = 8'd50;
        chk("t1_busy",     32'(busy),     32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("t1_latency", 32'(n), 32'(lat(3, 5)));
        chk("t1_p",       32'(p), 32'd56);
        tick();
        chk("t1_in_ready_after", 32'(in_ready),  32'd1);
        chk("t1_valid_after",    32'(out_valid), 32'd0);
        chk("t1_p_held_idle",    32'(p),         32'd56);

        // full-scale operands
        issue(8'd255, 8'd255, 8'd255, n);
        chk("t2_latency", 32'(n), 32'(lat(255, 255)));
        chk("t2_p",       32'(p), 32'd130050);
        tick();

        // zero multiplier
        issue(8'd0, 8'd0, 8'd200, n);
        chk("t3_latency", 32'(n), 32'(lat(0, 0)));
        chk("t3_p",       32'(p), 32'd0);
        tick();

        // backpressure: (10+6)*3 = 48 held for 5 stalled cycles
        out_ready = 1'b0;
        issue(8'd10, 8'd6, 8'd3, n);
        chk("t4_latency", 32'(n), 32'(lat(10, 6)));
        chk("t4_p",       32'(p), 32'd48);
        xs = 8'd9; xc = 8'd9; y = 8'd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_p",        32'(p),         32'd48);
            chk("t4_stall_valid",    32'(out_valid), 32'd1);
            chk("t4_stall_in_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t4_idle_in_ready", 32'(in_ready),  32'd1);
        chk("t4_idle_valid",    32'(out_valid), 32'd0);
        chk("t4_idle_p",        32'(p),         32'd48);

        // flush on the third BUSY cycle of (100+1)*9
        xs = 8'd100; xc = 8'd1; y = 8'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_in_ready", 32'(in_ready),  32'd1);
        chk("t5_busy",     32'(busy),      32'd0);
        chk("t5_p",        32'(p),         32'd0);
        chk("t5_valid",    32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("t5_no_valid_later", 32'(seen), 32'd0);
        // flush in IDLE together with in_valid must not accept
        xs = 8'd7; xc = 8'd7; y = 8'd7; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("t5_flush_idle_busy",     32'(busy),     32'd0);
        chk("t5_flush_idle_in_ready", 32'(in_ready), 32'd1);
        issue(8'd2, 8'd2, 8'd5, n);
        chk("t5b_latency", 32'(n), 32'(lat(2, 2)));
        chk("t5b_p",       32'(p), 32'd20);
        tick();

        // async reset in the middle of BUSY
        xs = 8'd255; xc = 8'd255; y = 8'd255; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready),  32'd1);
        chk("t6_rst_valid",    32'(out_valid), 32'd0);
        chk("t6_rst_p",        32'(p),         32'd0);
        chk("t6_rst_busy",     32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(8'd1, 8'd1, 8'd1, n);
        chk("t6b_latency", 32'(n), 32'(lat(1, 1)));
        chk("t6b_p",       32'(p), 32'd2);
        tick();

        // low-digit-only operand: early termination visible in latency
        issue(8'd1, 8'd0, 8'd9, n);
        chk("t7_latency", 32'(n), ET ? 32'd1 : 32'd8);
        chk("t7_p",       32'(p), 32'd9);
        tick();
        chk("t7_in_ready_after", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
